// File: rtl/sevenseg_fe_multi.sv
// Seven-segment front end: single or split fields, hex or decimal (iterative double-dabble).
// Optional signed-decimal support is enabled by defining SEVENSEG_FE_SIGNED_EN.
module sevenseg_fe_multi #(
    parameter int unsigned DIGITS     = 8,
    parameter int unsigned FIELDS     = 2,
    parameter int unsigned MIN_DIGITS = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [4*DIGITS-1:0] input_value,
    input  logic                cfg_split,
    input  logic [FIELDS-1:0]   cfg_decimal,
`ifdef SEVENSEG_FE_SIGNED_EN
    input  logic [FIELDS-1:0]   cfg_signed,
    output logic [FIELDS-1:0]   negative,
`endif
    output logic [4*DIGITS-1:0] display,
    output logic [DIGITS-1:0]   digit_enable,
    output logic [FIELDS-1:0]   overflow,
    output logic                frame_done
);

    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned FW    = W / FIELDS;
    localparam int unsigned FD    = DIGITS / FIELDS;
    localparam int unsigned BD    = (W * 302 + 999) / 1000 + 1;
    localparam int unsigned CW    = $clog2(W + 1);
    localparam int unsigned MIN_S = (MIN_DIGITS > DIGITS) ? DIGITS : MIN_DIGITS;
    localparam int unsigned MIN_F = (MIN_DIGITS > FD) ? FD : MIN_DIGITS;
    localparam int unsigned FIW   = (FIELDS > 1) ? $clog2(FIELDS) : 1;

    function automatic logic [DIGITS-1:0] low_ones(int unsigned n);
        logic [DIGITS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < DIGITS; i++) m[i] = (i < n);
        return m;
    endfunction

    localparam logic [DIGITS-1:0] RST_EN = low_ones(MIN_S);

    typedef enum logic [1:0] {StLoad, StShift, StStore} state_e;

    state_e            state_q, state_d;
    logic [FIW-1:0]    fld_q, fld_d;
    logic              split_q, split_d;
    logic              dec_q, dec_d;
    logic [W-1:0]      raw_q, raw_d;
    logic [W-1:0]      bin_q, bin_d;
    logic [4*BD-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W-1:0]      disp_q, disp_d;
    logic [DIGITS-1:0] de_q, de_d;
    logic [FIELDS-1:0] ov_q, ov_d;
    logic              fd_q, fd_d;
`ifdef SEVENSEG_FE_SIGNED_EN
    logic              neg_q, neg_d, neg_bit;
    logic [FIELDS-1:0] nout_q, nout_d;
`endif

    logic [FW-1:0]     fslice;
    logic [W-1:0]      slice, mag;
    logic [CW-1:0]     aw;
    logic              dec_bit;

    always_comb begin
        fslice  = input_value[FW*int'(fld_q) +: FW];
        slice   = cfg_split ? W'(fslice) : input_value;
        aw      = cfg_split ? CW'(FW) : CW'(W);
        dec_bit = cfg_split ? cfg_decimal[fld_q] : cfg_decimal[0];
        mag     = slice;
`ifdef SEVENSEG_FE_SIGNED_EN
        neg_bit = 1'b0;
        if (cfg_split && cfg_signed[fld_q] && dec_bit && fslice[FW-1]) begin
            mag     = W'(-fslice);
            neg_bit = 1'b1;
        end else if (!cfg_split && cfg_signed[0] && dec_bit && slice[W-1]) begin
            mag     = -slice;
            neg_bit = 1'b1;
        end
`endif
    end

    logic [4*(BD-1)-1:0] adj;
    logic                ov_f;
    logic [W-1:0]        nib;
    logic [DIGITS-1:0]   en_f;
    logic                any_nz;
    int                  top, n_dig, min_dig;

    // The top BCD digit never reaches 5 (one spare digit), so it is shifted without adjust.
    always_comb begin
        for (int i = 0; i < int'(BD) - 1; i++) begin
            adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        end
    end

    // Overflow forces all-F nibbles, which also lights every digit of the field.
    always_comb begin
        ov_f    = dec_q & (split_q ? (|bcd_q[4*BD-1:4*FD]) : (|bcd_q[4*BD-1:W]));
        nib     = ov_f ? '1 : (dec_q ? bcd_q[W-1:0] : raw_q);
        n_dig   = split_q ? int'(FD) : int'(DIGITS);
        min_dig = split_q ? int'(MIN_F) : int'(MIN_S);
        top     = 0;
        any_nz  = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (i < n_dig && nib[4*i +: 4] != 4'd0) begin
                top    = i;
                any_nz = 1'b1;
            end
        end
        for (int i = 0; i < int'(DIGITS); i++) begin
            en_f[i] = (i < n_dig) && ((any_nz && i <= top) || i < min_dig);
        end
    end

    always_comb begin
        state_d = state_q;
        fld_d   = fld_q;
        split_d = split_q;
        dec_d   = dec_q;
        raw_d   = raw_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        de_d    = de_q;
        ov_d    = ov_q;
        fd_d    = 1'b0;
`ifdef SEVENSEG_FE_SIGNED_EN
        neg_d   = neg_q;
        nout_d  = nout_q;
`endif
        if (cfg_split != split_q && !(state_q == StLoad && fld_q == '0)) begin
            state_d = StLoad;
            fld_d   = '0;
        end else begin
            case (state_q)
                StLoad: begin
                    split_d = cfg_split;
                    dec_d   = dec_bit;
                    raw_d   = slice;
                    bin_d   = cfg_split ? (mag << (W - FW)) : mag;
                    bcd_d   = '0;
                    cnt_d   = aw;
`ifdef SEVENSEG_FE_SIGNED_EN
                    neg_d   = neg_bit;
`endif
                    state_d = StShift;
                end
                StShift: begin
                    {bcd_d, bin_d} = {bcd_q[4*BD-2:4*BD-4], adj, bin_q, 1'b0};
                    cnt_d          = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = StStore;
                end
                StStore: begin
                    if (split_q) begin
                        disp_d[FW*int'(fld_q) +: FW] = nib[FW-1:0];
                        de_d[FD*int'(fld_q) +: FD]   = en_f[FD-1:0];
                        ov_d[fld_q]                  = ov_f;
`ifdef SEVENSEG_FE_SIGNED_EN
                        nout_d[fld_q]                = neg_q;
`endif
                    end else begin
                        disp_d  = nib;
                        de_d    = en_f;
                        ov_d    = '0;
                        ov_d[0] = ov_f;
`ifdef SEVENSEG_FE_SIGNED_EN
                        nout_d    = '0;
                        nout_d[0] = neg_q;
`endif
                    end
                    fd_d    = !split_q || fld_q == FIW'(FIELDS - 1);
                    fld_d   = fd_d ? '0 : fld_q + FIW'(1);
                    state_d = StLoad;
                end
                default: state_d = StLoad;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StLoad;
            fld_q   <= '0;
            split_q <= 1'b0;
            dec_q   <= 1'b0;
            raw_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            de_q    <= RST_EN;
            ov_q    <= '0;
            fd_q    <= 1'b0;
`ifdef SEVENSEG_FE_SIGNED_EN
            neg_q   <= 1'b0;
            nout_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            fld_q   <= fld_d;
            split_q <= split_d;
            dec_q   <= dec_d;
            raw_q   <= raw_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            de_q    <= de_d;
            ov_q    <= ov_d;
            fd_q    <= fd_d;
`ifdef SEVENSEG_FE_SIGNED_EN
            neg_q   <= neg_d;
            nout_q  <= nout_d;
`endif
        end
    end

    assign display      = disp_q;
    assign digit_enable = de_q;
    assign overflow     = ov_q;
    assign frame_done   = fd_q;
`ifdef SEVENSEG_FE_SIGNED_EN
    assign negative     = nout_q;
`endif

endmodule

// File: tb/tb_sevenseg_fe_multi.sv
// Scoreboard bench for sevenseg_fe_multi: two instances (MIN_DIGITS 1 and 3) share stimulus.
module tb_sevenseg_fe_multi;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] input_value;
    logic        cfg_split;
    logic [1:0]  cfg_decimal;
    logic [31:0] display, display3;
    logic [7:0]  digit_enable, de3;
    logic [1:0]  overflow, ov3;
    logic        frame_done, fd3;

    always #5 clk = ~clk;

    sevenseg_fe_multi #(.DIGITS(8), .FIELDS(2), .MIN_DIGITS(1)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .input_value  (input_value),
        .cfg_split    (cfg_split),
        .cfg_decimal  (cfg_decimal),
        .display      (display),
        .digit_enable (digit_enable),
        .overflow     (overflow),
        .frame_done   (frame_done)
    );

    sevenseg_fe_multi #(.DIGITS(8), .FIELDS(2), .MIN_DIGITS(3)) dut_m3 (
        .clk          (clk),
        .resetn       (resetn),
        .input_value  (input_value),
        .cfg_split    (cfg_split),
        .cfg_decimal  (cfg_decimal),
        .display      (display3),
        .digit_enable (de3),
        .overflow     (ov3),
        .frame_done   (fd3)
    );

    typedef struct {
        logic [31:0] disp;
        logic [7:0]  en;
        logic [7:0]  en3;
        logic [1:0]  ov;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: decimal digits by division, independent of double-dabble.
    function automatic exp_t model(logic [31:0] v, logic split, logic [1:0] dec);
        exp_t e;
        int   nf, nd;
        nf    = split ? 2 : 1;
        nd    = split ? 4 : 8;
        e.disp = '0;
        e.en   = '0;
        e.en3  = '0;
        e.ov   = '0;
        e.lat  = split ? 36 : 34;
        for (int f = 0; f < nf; f++) begin
            longint unsigned fv, x, lim;
            logic [31:0]     nibs;
            logic [7:0]      en1, en3;
            logic            ovf;
            int              top;
            fv   = {32'd0, (split ? ((v >> (16 * f)) & 32'h0000FFFF) : v)};
            lim  = 1;
            for (int k = 0; k < nd; k++) lim = lim * 10;
            nibs = '0;
            ovf  = 1'b0;
            if (dec[f]) begin
                if (fv >= lim) begin
                    ovf = 1'b1;
                    for (int k = 0; k < nd; k++) nibs[4*k +: 4] = 4'hF;
                end else begin
                    x = fv;
                    for (int k = 0; k < nd; k++) begin
                        nibs[4*k +: 4] = 4'(x % 10);
                        x = x / 10;
                    end
                end
            end else begin
                nibs = fv[31:0];
            end
            top = -1;
            for (int k = 0; k < nd; k++) if (nibs[4*k +: 4] != 4'd0) top = k;
            en1 = '0;
            en3 = '0;
            for (int k = 0; k < nd; k++) begin
                en1[k] = (k <= top) || (k < 1);
                en3[k] = (k <= top) || (k < 3);
            end
            e.disp = e.disp | (nibs << (16 * f));
            e.en   = e.en | (en1 << (4 * f));
            e.en3  = e.en3 | (en3 << (4 * f));
            e.ov[f] = ovf;
        end
        return e;
    endfunction

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (frame_done !== 1'b1 && n < 100);
        if (frame_done !== 1'b1) check_eq("frame_timeout", {63'd0, frame_done}, 64'd1);
    endtask

    task automatic drive(logic [31:0] v, logic split, logic [1:0] dec);
        input_value = v;
        cfg_split   = split;
        cfg_decimal = dec;
        sb_q.push_back(model(v, split, dec));
    endtask

    task automatic compare_frame(string tag, int n);
        exp_t e;
        e = sb_q.pop_front();
        check_eq({tag, "_lat"}, 64'(n), 64'(e.lat));
        check_eq({tag, "_disp"}, 64'(display), 64'(e.disp));
        check_eq({tag, "_en"}, 64'(digit_enable), 64'(e.en));
        check_eq({tag, "_ov"}, 64'(overflow), 64'(e.ov));
        check_eq({tag, "_disp3"}, 64'(display3), 64'(e.disp));
        check_eq({tag, "_en3"}, 64'(de3), 64'(e.en3));
        check_eq({tag, "_ov3"}, 64'(ov3), 64'(e.ov));
        check_eq({tag, "_fd3"}, {63'd0, fd3}, 64'd1);
    endtask

    // Caller must be synchronised to a frame_done so the FSM is about to LOAD field 0.
    task automatic apply(string tag, logic [31:0] v, logic split, logic [1:0] dec);
        int n;
        drive(v, split, dec);
        wait_frame(n);
        compare_frame(tag, n);
    endtask

    task automatic check_reset(string tag);
        check_eq({tag, "_disp"}, 64'(display), 64'd0);
        check_eq({tag, "_en"}, 64'(digit_enable), 64'h01);
        check_eq({tag, "_en3"}, 64'(de3), 64'h07);
        check_eq({tag, "_ov"}, 64'(overflow), 64'd0);
        check_eq({tag, "_fd"}, {63'd0, frame_done}, 64'd0);
    endtask

    initial begin
        int          n;
        logic        held;
        logic [31:0] snap_d;
        logic [7:0]  snap_e;
        logic [1:0]  snap_o;
        exp_t        e;

        resetn      = 1'b0;
        input_value = '0;
        cfg_split   = 1'b0;
        cfg_decimal = 2'b00;
        #12;
        check_reset("reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        sb_q.push_back(model(32'd0, 1'b0, 2'b00));
        wait_frame(n);
        compare_frame("rst_frame", n);

        apply("dec_single", 32'h00BC614E, 1'b0, 2'b01);
        apply("hex_ab", 32'h000000AB, 1'b0, 2'b00);
        apply("split_mix", 32'h1234270F, 1'b1, 2'b01);
        apply("dec_ovf", 32'hFFFFFFFF, 1'b0, 2'b01);
        apply("split_ovf", 32'h0000FFFF, 1'b1, 2'b11);
        apply("dec_max", 32'd99999999, 1'b0, 2'b01);
        apply("dec_min_ovf", 32'd100000000, 1'b0, 2'b01);
        apply("split_bound", 32'h2710270F, 1'b1, 2'b11);
        apply("dec_zero", 32'd0, 1'b0, 2'b01);
        apply("split_hex", 32'h00A00005, 1'b1, 2'b00);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] v;
            v = (i % 2 == 0) ? 32'($urandom_range(99999999, 0)) : $urandom;
            apply("rand", v, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)));
        end

        // Split frame with both fields overflowing, then leave split mode during field 1.
        apply("pre_switch", 32'h2710FFFF, 1'b1, 2'b11);
        for (int i = 0; i < 21; i++) begin
            @(posedge clk);
            #1;
        end
        snap_d      = display;
        snap_e      = digit_enable;
        snap_o      = overflow;
        input_value = 32'd12345;
        cfg_split   = 1'b0;
        cfg_decimal = 2'b01;
        e           = model(32'd12345, 1'b0, 2'b01);
        e.lat       = 35;  // one abort edge, then a full 34-cycle single conversion
        sb_q.push_back(e);
        held = 1'b1;
        n    = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (frame_done !== 1'b1) begin
                if (display !== snap_d || digit_enable !== snap_e || overflow !== snap_o)
                    held = 1'b0;
            end
        end while (frame_done !== 1'b1 && n < 100);
        if (frame_done !== 1'b1) check_eq("switch_timeout", {63'd0, frame_done}, 64'd1);
        check_eq("switch_hold", {63'd0, held}, 64'd1);
        compare_frame("switch_single", n);

        // Asynchronous reset in the middle of SHIFT.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        resetn = 1'b0;
        #1;
        check_reset("rst_mid");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        sb_q.push_back(model(input_value, cfg_split, cfg_decimal));
        wait_frame(n);
        compare_frame("rst_mid_frame", n);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
